pmem_loader: RTL and testbench
==============================

PMEM_LOADER -- requirements
Module: pmem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, width of the program memory address (256 words).
REQ-002 Parameter INSTR_W, default 12, width of one instruction word.
REQ-003 Parameter TIMEOUT, default 1024, maximum idle cycles between accepted beats while loading; legal range 2..65535.
REQ-004 clk  input  1  the single clock; all state is updated on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to begin a program load.
REQ-007 abort  input  1  cancels any load in progress.
REQ-008 prog_last  input  ADDR_W  last address to be written; sampled when start is accepted.
REQ-009 s_valid  input  1  instruction stream beat valid.
REQ-010 s_ready  output  1  loader accepts a beat this cycle.
REQ-011 s_instr  input  INSTR_W  instruction stream data.
REQ-012 pmem_le  output  1  program memory load enable.
REQ-013 pmem_la  output  ADDR_W  program memory load address.
REQ-014 pmem_li  output  INSTR_W  program memory load instruction.
REQ-015 cpu_hold  output  1  holds the core in its LOAD stage while high.
REQ-016 load_done  output  1  sticky flag: last load completed.
REQ-017 load_err  output  1  sticky flag: last load timed out.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, DONE and ERR.
REQ-019 IDLE: start=1 and abort=0 -> LOAD; addr<=0, last<=prog_last, timer<=0, load_done<=0, load_err<=0.
REQ-020 LOAD: s_ready=1 and cpu_hold=1 whenever abort=0.
REQ-021 A beat is accepted when s_valid&s_ready; pmem_le=1, pmem_la=addr and pmem_li=s_instr in the same cycle (combinational, zero latency), so the write lands on that edge.
REQ-022 pmem_le SHALL be 0 in every cycle without an accepted beat; pmem_la=addr and pmem_li=s_instr otherwise (don't-care).
REQ-023 Accepted beat with addr!=last: addr<=addr+1, timer<=0.
REQ-024 Accepted beat with addr==last -> DONE; addr<=0; total writes = last+1; prog_last=0 writes exactly one word.
REQ-025 No beat in LOAD: timer<=timer+1; when timer==TIMEOUT-1 -> ERR.
REQ-026 A beat and a timer expiry in the same cycle: the beat wins, it is written and the timer clears.
REQ-027 DONE: cpu_hold=0, load_done<=1, unconditional -> IDLE next cycle.
REQ-028 ERR: cpu_hold=1, load_err<=1, s_ready=0; start -> LOAD as in REQ-019; abort -> IDLE.
REQ-029 abort=1 in LOAD: -> IDLE, s_ready=0, pmem_le=0 that cycle (abort beats a simultaneous beat), flags unchanged.
REQ-030 start while in LOAD or DONE SHALL be ignored; start and abort together in IDLE: abort wins, remain IDLE.
REQ-031 addr never wraps; prog_last=2^ADDR_W-1 fills the whole memory and then -> DONE.
REQ-032 cpu_hold SHALL be 0 in IDLE.

Reset
REQ-033 rst=1 asynchronously forces IDLE, addr=0, last=0, timer=0, load_done=0, load_err=0.
REQ-034 During reset, outputs SHALL be s_ready=0, pmem_le=0, cpu_hold=0.
REQ-035 rst asserted during LOAD abandons the load with no further pmem_le; memory contents already written are untouched.

Structure
REQ-036 A shared package pmem_loader_pkg SHALL hold the state encoding (IDLE=2'b00, LOAD=2'b01, DONE=2'b10, ERR=2'b11) and the default ADDR_W/INSTR_W constants.
REQ-037 The timeout counter SHALL be one sub-module, beat_timer (clear, enable, expired output, width of ceil(log2(TIMEOUT)) bits).

Verification
REQ-038 Reset, then start with prog_last=25 and 26 back-to-back beats -> pmem_le high 26 cycles at la 0..25, load_done=1 one cycle after the last beat, cpu_hold 0.
REQ-039 prog_last=3, s_valid toggled 1,0,1,0,... -> exactly 4 writes at la 0,1,2,3 carrying the matching s_instr, and no pmem_le in gap cycles.
REQ-040 TIMEOUT=8, start, one beat, then s_valid=0 -> ERR after exactly 8 idle cycles, load_err=1, s_ready=0; start then restarts at la=0.
REQ-041 Abort asserted on the same cycle as the 3rd beat -> no write at la=2, IDLE next cycle, load_done=0.
REQ-042 rst pulsed mid-load (addr=10), then start with prog_last=0 and one beat -> single write at la=0, load_done=1.
REQ-043 start asserted during LOAD at addr=5 -> ignored; the load continues to prog_last without an address reset.

Source files
------------

// File: rtl/pmem_loader_pkg.sv
// Shared definitions for the program memory loader: FSM state encoding,
// default geometry constants and the timeout counter width helper.
package pmem_loader_pkg;

  // Default geometry: 256 instruction words of 12 bits each.
  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 12;

  // Default number of idle cycles tolerated between accepted beats.
  localparam int TIMEOUT_DEF = 1024;

  // Loader FSM states. The encoding is visible on the debug state output.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_DONE = 2'b10,
    ST_ERR  = 2'b11
  } state_t;

  // Counter width able to hold 0..timeout-1, never narrower than one bit.
  function automatic int timer_width(input int timeout);
    int w;
    w = $clog2(timeout);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/pmem_loader_beat_timer.sv
// Idle-cycle counter for the loader. Counts enabled cycles since the last
// clear and flags the cycle in which the count reaches TIMEOUT-1.
module beat_timer
  import pmem_loader_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = timer_width(TIMEOUT);
  localparam logic [W-1:0] LAST_CNT = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  // Clear has priority over counting; the count saturates at LAST_CNT so an
  // enabled counter left in place can never wrap back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST_CNT)) begin
      count <= count + W'(1);
    end
  end

  // Expiry is combinational so the FSM can act in the same cycle.
  always_comb begin
    expired = (count == LAST_CNT);
  end

endmodule

// File: rtl/pmem_loader.sv
// Program memory loader: takes a valid/ready instruction stream and writes it
// into program memory from address 0 up to a sampled last address, holding
// the core while loading and reporting completion or timeout via sticky flags.
//
// Stream handshake: a beat transfers in any cycle where s_valid and s_ready
// are both high at the rising edge. s_ready depends only on the loader state
// and abort, never on s_valid. The memory write for a beat is presented
// combinationally (pmem_le/pmem_la/pmem_li) in that same cycle, so the word
// lands in memory on the edge that accepts the beat.
module pmem_loader
  import pmem_loader_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [ADDR_W-1:0]  prog_last,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [INSTR_W-1:0] s_instr,
  output logic               pmem_le,
  output logic [ADDR_W-1:0]  pmem_la,
  output logic [INSTR_W-1:0] pmem_li,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_err,
  output logic [1:0]         dbg_state
);

  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   last;
  logic                beat;
  logic                begin_load;
  logic                tmr_clear;
  logic                tmr_enable;
  logic                tmr_expired;

  // Handshake, memory write port and hold decode from the current state.
  always_comb begin
    s_ready  = (state == ST_LOAD) && !abort;
    beat     = s_valid && s_ready;
    pmem_le  = beat;
    pmem_la  = addr;
    pmem_li  = s_instr;
    cpu_hold = ((state == ST_LOAD) && !abort) || (state == ST_ERR);
  end

  // A new load may begin from IDLE or ERR; abort always wins over start.
  always_comb begin
    begin_load = start && !abort && ((state == ST_IDLE) || (state == ST_ERR));
  end

  // The timer only runs in LOAD between beats; it is held at zero elsewhere
  // so every load starts with a fresh idle budget.
  always_comb begin
    tmr_clear  = (state != ST_LOAD) || beat;
    tmr_enable = (state == ST_LOAD) && !abort && !beat;
  end

  beat_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_beat_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .expired (tmr_expired)
  );

  // Loader FSM with address, last-address and sticky status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      addr      <= '0;
      last      <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (begin_load) begin
            state     <= ST_LOAD;
            addr      <= '0;
            last      <= prog_last;
            load_done <= 1'b0;
            load_err  <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            // Abandon the load; status flags keep their values.
            state <= ST_IDLE;
          end else if (beat) begin
            // A beat beats a simultaneous timer expiry.
            if (addr == last) begin
              state     <= ST_DONE;
              addr      <= '0;
              load_done <= 1'b1;
            end else begin
              addr <= addr + ADDR_W'(1);
            end
          end else if (tmr_expired) begin
            state    <= ST_ERR;
            load_err <= 1'b1;
          end
        end
        ST_DONE: begin
          // One release cycle with the core un-held, then back to IDLE.
          load_done <= 1'b1;
          state     <= ST_IDLE;
        end
        ST_ERR: begin
          load_err <= 1'b1;
          if (abort) begin
            state <= ST_IDLE;
          end else if (begin_load) begin
            state     <= ST_LOAD;
            addr      <= '0;
            last      <= prog_last;
            load_done <= 1'b0;
            load_err  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Debug view of the FSM state.
  always_comb begin
    dbg_state = state;
  end

endmodule

// File: tb/tb_pmem_loader.sv
// Self-checking bench for pmem_loader: table-driven loads, directed corner
// sequences and randomized traffic, all compared cycle by cycle against a
// behavioural model of the loader's rules and a write scoreboard.
module tb_pmem_loader;

  localparam int AW = 8;
  localparam int IW = 12;
  localparam int TO = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [AW-1:0] prog_last;
  logic          s_valid;
  logic          s_ready;
  logic [IW-1:0] s_instr;
  logic          pmem_le;
  logic [AW-1:0] pmem_la;
  logic [IW-1:0] pmem_li;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;
  logic [1:0]    dbg_state;

  pmem_loader #(
    .ADDR_W  (AW),
    .INSTR_W (IW),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .prog_last (prog_last),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_instr   (s_instr),
    .pmem_le   (pmem_le),
    .pmem_la   (pmem_la),
    .pmem_li   (pmem_li),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  // Expected memory writes, {address, instruction}, in issue order.
  logic [AW+IW-1:0] exp_q[$];

  // Behavioural model: a load is a count of words still owed, the next
  // address to fill, and a run length of consecutive idle cycles.
  bit m_loading;
  bit m_finishing;
  bit m_stalled;
  int m_next;
  int m_words_left;
  int m_idle;
  bit m_done;
  bit m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_loading    = 0;
    m_finishing  = 0;
    m_stalled    = 0;
    m_next       = 0;
    m_words_left = 0;
    m_idle       = 0;
    m_done       = 0;
    m_err        = 0;
    exp_q.delete();
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input bit st, input bit ab, input logic [AW-1:0] pl,
                       input bit sv, input logic [IW-1:0] si);
    bit         e_ready;
    bit         e_le;
    logic [1:0] e_code;
    logic [AW+IW-1:0] got;
    logic [AW+IW-1:0] want;
    @(negedge clk);
    start     = st;
    abort     = ab;
    prog_last = pl;
    s_valid   = sv;
    s_instr   = si;
    #1;
    e_ready = m_loading && !ab;
    e_le    = e_ready && sv;
    if (m_loading)        e_code = 2'b01;
    else if (m_finishing) e_code = 2'b10;
    else if (m_stalled)   e_code = 2'b11;
    else                  e_code = 2'b00;
    check("s_ready", s_ready, e_ready);
    check("pmem_le", pmem_le, e_le);
    if (!(m_loading && ab)) check("cpu_hold", cpu_hold, m_loading || m_stalled);
    check("load_done", load_done, m_done);
    check("load_err", load_err, m_err);
    check("dbg_state", dbg_state, e_code);
    if (e_le) exp_q.push_back({AW'(m_next), si});
    // Scoreboard: every DUT write must match the oldest expected write.
    if (pmem_le === 1'b1) begin
      wr_cnt++;
      got = {pmem_la, pmem_li};
      if (exp_q.size() == 0) begin
        check("unexpected_write", got, '1);
      end else begin
        want = exp_q.pop_front();
        check("write_la_li", got, want);
      end
    end
    // Advance the model across the coming edge.
    if (m_loading) begin
      if (ab) begin
        m_loading = 0;
      end else if (sv) begin
        m_words_left--;
        m_idle = 0;
        if (m_words_left == 0) begin
          m_loading   = 0;
          m_finishing = 1;
          m_done      = 1;
        end else begin
          m_next++;
        end
      end else if (m_idle == TO - 1) begin
        m_loading = 0;
        m_stalled = 1;
        m_err     = 1;
      end else begin
        m_idle++;
      end
    end else if (m_finishing) begin
      m_finishing = 0;
    end else if (ab) begin
      m_stalled = 0;
    end else if (st) begin
      m_stalled    = 0;
      m_loading    = 1;
      m_next       = 0;
      m_words_left = int'(pl) + 1;
      m_idle       = 0;
      m_done       = 0;
      m_err        = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    s_valid = 1'b0;
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_pmem_le", pmem_le, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_load_done", load_done, 0);
    check("rst_load_err", load_err, 0);
    check("rst_state", dbg_state, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle_cycle();
    cycle(0, 0, '0, 0, '0);
  endtask

  task automatic beat_cycle();
    cycle(0, 0, '0, 1, IW'($urandom));
  endtask

  // ---------------- table of whole loads ----------------
  typedef struct {
    logic [AW-1:0] pl;
    int            gap;         // s_valid high one cycle in every gap
    int            abort_beat;  // beat index carrying abort, -1 for none
    int            exp_writes;
    bit            exp_done;
    bit            exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    start     = 1'b0;
    abort     = 1'b0;
    prog_last = '0;
    s_valid   = 1'b0;
    s_instr   = '0;
    rst       = 1'b1;
    model_reset();

    vecs[0] = '{pl: 8'd25,  gap: 1, abort_beat: -1, exp_writes: 26,  exp_done: 1, exp_err: 0};
    vecs[1] = '{pl: 8'd3,   gap: 2, abort_beat: -1, exp_writes: 4,   exp_done: 1, exp_err: 0};
    vecs[2] = '{pl: 8'd0,   gap: 1, abort_beat: -1, exp_writes: 1,   exp_done: 1, exp_err: 0};
    vecs[3] = '{pl: 8'd9,   gap: 1, abort_beat: 2,  exp_writes: 2,   exp_done: 0, exp_err: 0};
    vecs[4] = '{pl: 8'd255, gap: 1, abort_beat: -1, exp_writes: 256, exp_done: 1, exp_err: 0};
    vecs[5] = '{pl: 8'd7,   gap: 3, abort_beat: -1, exp_writes: 8,   exp_done: 1, exp_err: 0};

    do_reset();

    for (int v = 0; v < 6; v++) begin
      int beat_n;
      int k;
      wr_cnt = 0;
      beat_n = 0;
      cycle(1, 0, vecs[v].pl, 0, '0);
      k = 0;
      while (m_loading && k < 2000) begin
        bit sv;
        bit ab;
        sv = ((k % vecs[v].gap) == 0);
        ab = sv && (beat_n == vecs[v].abort_beat);
        cycle(0, ab, '0, sv, IW'($urandom));
        if (sv) beat_n++;
        k++;
      end
      check("load_budget", {31'd0, m_loading}, 0);
      idle_cycle();
      check("vec_writes", wr_cnt, vecs[v].exp_writes);
      check("vec_done", load_done, vecs[v].exp_done);
      check("vec_err", load_err, vecs[v].exp_err);
      check("vec_sb_empty", exp_q.size(), 0);
      check("vec_hold_released", cpu_hold, 0);
    end

    // Timeout: one beat, then exactly TO idle cycles lead to ERR.
    wr_cnt = 0;
    cycle(1, 0, 8'd10, 0, '0);
    beat_cycle();
    for (int i = 0; i < TO; i++) begin
      idle_cycle();
      check("to_still_loading", s_ready, 1);
    end
    idle_cycle();
    check("to_err_ready", s_ready, 0);
    check("to_err_flag", load_err, 1);
    check("to_err_state", dbg_state, 2'b11);
    check("to_err_hold", cpu_hold, 1);
    // Restart from ERR begins again at address 0.
    cycle(1, 0, 8'd1, 0, '0);
    beat_cycle();
    check("to_restart_la", pmem_la, 0);
    check("to_restart_le", pmem_le, 1);
    beat_cycle();
    idle_cycle();
    check("to_restart_done", load_done, 1);
    check("to_restart_err_clr", load_err, 0);
    // Second timeout, then abort returns to IDLE.
    cycle(1, 0, 8'd4, 0, '0);
    for (int i = 0; i < TO + 1; i++) idle_cycle();
    check("to2_err", dbg_state, 2'b11);
    cycle(0, 1, '0, 0, '0);
    idle_cycle();
    check("err_abort_idle", dbg_state, 2'b00);
    check("err_abort_hold", cpu_hold, 0);

    // Reset in the middle of a load, then a one-word load.
    cycle(1, 0, 8'd20, 0, '0);
    for (int i = 0; i < 10; i++) beat_cycle();
    do_reset();
    wr_cnt = 0;
    cycle(1, 0, 8'd0, 0, '0);
    beat_cycle();
    check("rst_reload_la", pmem_la, 0);
    idle_cycle();
    check("rst_reload_writes", wr_cnt, 1);
    check("rst_reload_done", load_done, 1);

    // Start during LOAD at address 5 is ignored.
    wr_cnt = 0;
    cycle(1, 0, 8'd9, 0, '0);
    for (int i = 0; i < 5; i++) beat_cycle();
    cycle(1, 0, 8'd2, 1, IW'($urandom));
    check("start_in_load_la", pmem_la, 5);
    for (int i = 0; i < 4; i++) beat_cycle();
    idle_cycle();
    check("start_in_load_writes", wr_cnt, 10);
    check("start_in_load_done", load_done, 1);

    // Start and abort together in IDLE: stay IDLE.
    cycle(1, 1, 8'd5, 0, '0);
    cycle(0, 0, '0, 1, '0);
    check("start_abort_idle", s_ready, 0);
    check("start_abort_state", dbg_state, 2'b00);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 11) == 0, $urandom_range(0, 39) == 0,
            AW'($urandom_range(0, 12)), $urandom_range(0, 9) < 6, IW'($urandom));
    end
    for (int i = 0; i < 40; i++) idle_cycle();
    check("final_sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
